seq_shifter: RTL
================

Name: seq_shifter

Overview:
- Parametrised multi-cycle shifter for the datapath; generalises the fixed left-shift-by-2 unit.
- Supports variable shift amount and four modes: logical left, logical right, arithmetic right and rotate left.
- Shifts by at most STEP bit positions per clock, so a small shift stage replaces a full barrel shifter.
- Uses a start/busy/done handshake toward the controller FSM.

Parameters:
- WIDTH, 32, data width in bits (≥2)
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH)
- STEP, 4, maximum bit positions shifted per clock (1..WIDTH-1)

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only when not busy
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROTL
- a  input  WIDTH  operand, captured with start
- shamt  input  SHAMT_W  shift amount (0..WIDTH-1), captured with start
- busy  output  1  high while shifting
- done  output  1  one-cycle pulse, result valid
- y  output  WIDTH  result register

Behaviour:
- States: IDLE, SHIFT, DONE.
  - busy = (state==SHIFT).
  - done = (state==DONE).
  - y is registered.
- Reset (reset low, asynchronous): state=IDLE, busy=0, done=0, y=0, internal data/count registers cleared.
  - Reset mid-SHIFT aborts the operation. No done pulse is produced.
- Start acceptance: start is accepted at a rising edge when state is IDLE or DONE.
  - start while in SHIFT is ignored and not queued. a/op/shamt changes during SHIFT have no effect.
- On an accepted start:
  - op, a and shamt are latched.
  - shamt==0: y<=a; next state DONE.
  - shamt!=0: data<=a, rem<=shamt; next state SHIFT.
- SHIFT, every edge:
  - k = min(STEP, rem).
  - data shifted by k per latched op:
    - SLL fills zeros from the LSB side.
    - SRL fills zeros from the MSB side.
    - SRA fills copies of data[WIDTH-1].
    - ROTL wraps bits from the MSB into the LSB.
  - rem <= rem-k.
  - If rem-k==0: y<=shifted data; next state DONE. Otherwise stay in SHIFT.
- Latency: N = ceil(shamt/STEP) SHIFT cycles. done is high in the clock cycle following the (N+1)th edge counting the start edge (N=0 for shamt=0).
- DONE lasts exactly one cycle.
  - Next state IDLE, or a new operation if start is asserted in that cycle (back-to-back allowed).
- y holds its value from DONE until the next operation completes. It is not cleared on return to IDLE.
- Arithmetic rules:
  - Result must equal the single-step reference: a<<shamt, a>>shamt, $signed(a)>>>shamt, or (a<<shamt)|(a>>(WIDTH-shamt)), truncated to WIDTH.
  - shamt is unsigned; no overflow flag.
- No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=32, STEP=4. SLL a=0x00000001, shamt=2 -> busy for 1 cycle, done in 2nd cycle after start edge, y=0x00000004.
2. SRA a=0x80000000, shamt=31 -> 8 SHIFT cycles, y=0xFFFFFFFF. Same operand with SRL -> y=0x00000001.
3. ROTL a=0x80000001, shamt=4 -> y=0x00000018. shamt=0 with any op, a=0xDEADBEEF -> busy never high, done next cycle, y=0xDEADBEEF.
4. Handshake: start again with a=0xFFFFFFFF during SHIFT of op SLL a=1 shamt=8 -> ignored, y=0x00000100. Start asserted in the DONE cycle -> second op accepted back-to-back.
5. Reset: assert reset low mid-SHIFT (asynchronously, between edges) -> busy/done/y read 0 immediately, no done pulse. After release, a new op completes correctly.
6. Random sweep: 1000 ops × all op/shamt values with STEP ∈ {1,4,7}.
   - Each y must match the reference expression.
   - done cycle must equal ceil(shamt/STEP)+1 cycles after the start edge.

Source files
------------

// File: rtl/seq_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROTL) that moves at most STEP bit positions per clock.
// Latency: done pulses ceil(shamt/STEP)+1 edges after the start edge (shamt==0 -> 1 edge).
// Backpressure: start is ignored while busy; a start in the done cycle chains back-to-back.
module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0]         OP_SLL   = 2'd0;
    localparam logic [1:0]         OP_SRL   = 2'd1;
    localparam logic [1:0]         OP_SRA   = 2'd2;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);
    localparam logic [SHAMT_W:0]   WIDTH_AMT = (SHAMT_W+1)'(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] k;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [SHAMT_W:0]   k_inv;
    logic [WIDTH-1:0]   shifted;
    logic               accept;

    assign accept = start && (state != SHIFT);
    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);

    // Single small shift stage: only amounts 0..STEP ever reach these shifters.
    always_comb begin
        k       = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
        rem_nxt = rem_q - k;
        k_inv   = WIDTH_AMT - {1'b0, k};
        case (op_q)
            OP_SLL:  shifted = data_q << k;
            OP_SRL:  shifted = data_q >> k;
            OP_SRA:  shifted = $unsigned($signed(data_q) >>> k);
            default: shifted = (data_q << k) | (data_q >> k_inv);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    state_nxt = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_nxt == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // y only changes when an operation completes; it is held through IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            data_q <= '0;
            rem_q  <= '0;
            y      <= '0;
        end else if (accept) begin
            op_q   <= op;
            data_q <= a;
            rem_q  <= shamt;
            if (shamt == '0) begin
                y <= a;
            end
        end else if (state == SHIFT) begin
            data_q <= shifted;
            rem_q  <= rem_nxt;
            if (rem_nxt == '0) begin
                y <= shifted;
            end
        end
    end

endmodule
